// File: rtl/regfile_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_sched
// Purpose  : Writeback scheduler and busy scoreboard for the 32x32 register
//            file (single write port, x0 hardwired to zero). Picks one of
//            NREQ writeback sources per cycle by round-robin, registers the
//            winner onto the regfile write port, and tracks in-flight
//            destinations so the issue stage can detect RAW/WAW hazards.
// Ports    : clk, rst (async, active-high)
//            chk_rs1/chk_rs2/chk_rd/chk_rd_we/issue_valid -> hazard
//            wb_valid/wb_rd/wb_data (packed per requester) -> wb_ready
//            rf_we/rf_wa/rf_wd : registered write port
//            busy_vec          : scoreboard state (bit 0 always 0)
//            err_unbusy        : sticky, writeback to a non-busy register
// Options  : REGFILE_WB_SCHED_FWD_EN adds fwd1/fwd2 bypass outputs and lets
//            hazard ignore sources being written back this cycle.
// Revision : 1.0  initial release
// ============================================================================
module regfile_wb_sched #(
  parameter int NREQ = 2,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           chk_rs1,
  input  logic [4:0]           chk_rs2,
  input  logic [4:0]           chk_rd,
  input  logic                 chk_rd_we,
  output logic                 hazard,
  input  logic                 issue_valid,
  input  logic [NREQ-1:0]      wb_valid,
  input  logic [NREQ*5-1:0]    wb_rd,
  input  logic [NREQ*XLEN-1:0] wb_data,
  output logic [NREQ-1:0]      wb_ready,
  output logic                 rf_we,
  output logic [4:0]           rf_wa,
  output logic [XLEN-1:0]      rf_wd,
  output logic [31:0]          busy_vec,
`ifdef REGFILE_WB_SCHED_FWD_EN
  output logic                 fwd1_valid,
  output logic                 fwd2_valid,
  output logic [XLEN-1:0]      fwd1_data,
  output logic [XLEN-1:0]      fwd2_data,
`endif
  output logic                 err_unbusy
);

  // Pointer is sized for the largest supported NREQ (4).
  localparam int PTR_W = 2;

  logic [31:0]      r_busy;
  logic [PTR_W-1:0] r_ptr;
  logic             r_err;

  logic [NREQ-1:0]  w_grant;
  logic             w_any;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [4:0]       w_sel_rd;
  logic [XLEN-1:0]  w_sel_data;
  logic             w_set;
  logic [31:0]      w_busy_nxt;
  logic             w_unbusy;
  logic             w_src1;
  logic             w_src2;
  logic             w_dst;

  // ---------------- round-robin arbiter ----------------
  // Offset k walks away from the pointer; the first requester hit wins.
  always_comb begin
    w_grant   = '0;
    w_any     = 1'b0;
    w_ptr_nxt = r_ptr;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_any && wb_valid[i] && (i == ((int'(r_ptr) + k) % NREQ))) begin
          w_any      = 1'b1;
          w_grant[i] = 1'b1;
          w_ptr_nxt  = PTR_W'((i + 1) % NREQ);
        end
      end
    end
  end

  assign wb_ready = w_grant;

  // One-hot grant makes an OR-mux sufficient.
  always_comb begin
    w_sel_rd   = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_rd   = w_sel_rd   | wb_rd[5*i +: 5];
        w_sel_data = w_sel_data | wb_data[XLEN*i +: XLEN];
      end
    end
  end

  // ---------------- scoreboard ----------------
  assign w_set = issue_valid & chk_rd_we & (chk_rd != 5'd0);

  // Clear first, then set, so a same-edge set/clear leaves the bit busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (rf_we) w_busy_nxt[rf_wa] = 1'b0;
    if (w_set) w_busy_nxt[chk_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  assign w_unbusy = w_any & (w_sel_rd != 5'd0) & ~r_busy[w_sel_rd] &
                    ~(w_set & (chk_rd == w_sel_rd));

  // ---------------- hazard detection ----------------
  assign w_dst = chk_rd_we & (chk_rd != 5'd0) & r_busy[chk_rd];

`ifdef REGFILE_WB_SCHED_FWD_EN
  // A source committed by the current rf_we is bypassed instead of stalled.
  assign fwd1_valid = rf_we & (rf_wa == chk_rs1) & (chk_rs1 != 5'd0);
  assign fwd2_valid = rf_we & (rf_wa == chk_rs2) & (chk_rs2 != 5'd0);
  assign fwd1_data  = rf_wd;
  assign fwd2_data  = rf_wd;
  assign w_src1 = r_busy[chk_rs1] & (chk_rs1 != 5'd0) & ~fwd1_valid;
  assign w_src2 = r_busy[chk_rs2] & (chk_rs2 != 5'd0) & ~fwd2_valid;
`else
  assign w_src1 = r_busy[chk_rs1] & (chk_rs1 != 5'd0);
  assign w_src2 = r_busy[chk_rs2] & (chk_rs2 != 5'd0);
`endif

  assign hazard     = w_src1 | w_src2 | w_dst;
  assign busy_vec   = r_busy;
  assign err_unbusy = r_err;

  // ---------------- sequential state ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_ptr  <= '0;
      r_err  <= 1'b0;
      rf_we  <= 1'b0;
      rf_wa  <= '0;
      rf_wd  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_any) begin
        // x0 writebacks are consumed but never reach the regfile.
        rf_we <= (w_sel_rd != 5'd0);
        rf_wa <= w_sel_rd;
        rf_wd <= w_sel_data;
        r_ptr <= w_ptr_nxt;
      end else begin
        rf_we <= 1'b0;
      end
      if (w_unbusy) r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
Writeback scheduler and register scoreboard in front of the 32x32 register file (single write port, x0 hardwired zero).
- Arbitrates NREQ writeback sources (ALU, LSU, mul/div, ...) onto the single write port, round-robin.
- Tracks in-flight destination registers in a busy scoreboard and reports RAW/WAW hazards to the issue stage.
- Sits between the execute units and the register file write port.

Parameters:
NREQ, 2, number of writeback requesters (2..4)
XLEN, 32, data width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
chk_rs1  in  5  issue-stage source 1 index
chk_rs2  in  5  issue-stage source 2 index
chk_rd  in  5  issue-stage destination index
chk_rd_we  in  1  instruction in issue writes chk_rd
hazard  out  1  combinational; issue must stall
issue_valid  in  1  instruction leaves issue this cycle; marks chk_rd busy when chk_rd_we
wb_valid  in  NREQ  per-requester writeback request
wb_rd  in  NREQ*5  per-requester destination, requester i at bits [5i+4:5i]
wb_data  in  NREQ*XLEN  per-requester data, requester i at bits [XLEN*i+XLEN-1:XLEN*i]
wb_ready  out  NREQ  combinational one-hot grant
rf_we  out  1  register file write enable (registered)
rf_wa  out  5  register file write address (registered)
rf_wd  out  XLEN  register file write data (registered)
busy_vec  out  32  scoreboard state; bit 0 always 0
err_unbusy  out  1  sticky error: writeback to a non-busy register

Behaviour:
- Reset (async, immediate):
  - busy_vec=0, rf_we=0, rf_wa=0, rf_wd=0, err_unbusy=0.
  - Round-robin pointer=0.
  - Output registers clear even if a write was pending.
- hazard = (busy[chk_rs1] & chk_rs1!=0) | (busy[chk_rs2] & chk_rs2!=0) | (chk_rd_we & chk_rd!=0 & busy[chk_rd]).
  - issue_valid while hazard=1 is a protocol violation; behaviour is undefined.
- Scoreboard update (per clock edge):
  - Set: issue_valid & chk_rd_we & chk_rd!=0 sets busy[chk_rd].
  - Clear: rf_we=1 clears busy[rf_wa].
  - Same register set and cleared on the same edge: set wins.
- Arbitration:
  - Round-robin among the asserted wb_valid bits, starting the search at the pointer.
  - wb_ready is one-hot, or all zero when no wb_valid is asserted.
  - The regfile port never stalls, so one grant is made every cycle a request exists.
  - After a grant to requester g, pointer = (g+1) mod NREQ. Pointer holds when there is no grant.
  - Requesters hold wb_valid, wb_rd and wb_data stable until granted.
- Output stage, 1-cycle latency: on the edge after grant g:
  - rf_we = (wb_rd[g]!=0)
  - rf_wa = wb_rd[g]
  - rf_wd = wb_data[g]
  - No grant in the cycle: rf_we=0, and rf_wa/rf_wd hold their values.
- x0 writebacks: granted and consumed normally, rf_we stays 0, no scoreboard effect.
- Busy clears on the same edge the register file commits the write. The first cycle hazard drops, rd1/rd2 already return the new value.
- err_unbusy is set when a grant targets a register with rd!=0 whose busy bit is 0 and is not being set on that edge.
  - The write is still performed.
  - Cleared only by rst.

Optional Feature:
Macro REGFILE_WB_SCHED_FWD_EN.
- Defined:
  - Adds outputs fwd1_valid, fwd2_valid (1 bit each) and fwd1_data, fwd2_data (XLEN each).
  - fwdN_valid=1 when rf_we & rf_wa==chk_rsN & chk_rsN!=0; fwdN_data=rf_wd.
  - hazard ignores a source whose busy bit is being cleared by this rf_we, allowing issue one cycle earlier.
  - The rd/WAW term is unchanged.
- Undefined: the ports are absent, and hazard is exactly as in Behaviour.

Test Plan:
- Reset mid-write: rf_we=1, rf_wa=5 pending, busy[5]=1; assert rst -> rf_we=0, busy_vec=0 immediately, before the next clk edge.
- Issue rd=3, then wb from req0 (rd=3, data 0xDEADBEEF) -> busy[3]=1 after issue; wb_ready=01; next cycle rf_we=1, rf_wa=3, rf_wd=0xDEADBEEF; busy[3]=0 the cycle after; hazard for chk_rs1=3 drops then.
- Both requesters valid continuously (rd=4, rd=6, both busy) -> grants alternate 01,10,01,... starting with req0; one rf_we per cycle.
- Writeback with rd=0, data 0x1234 -> wb_ready asserted; rf_we stays 0; busy_vec unchanged; err_unbusy stays 0.
- Edge where rf_we clears busy[7] and issue sets rd=7 -> busy[7]=1 afterwards.
- Writeback to non-busy x9 -> rf_we=1, rf_wa=9; err_unbusy=1 and stays set until rst.
